hot_page_mig_dispatcher: RTL and testbench

HOT_PAGE_MIG_DISPATCHER -- requirements
Module: hot_page_mig_dispatcher

---
 rtl/hot_page_mig_dispatcher_pkg.sv | 25 ++
 rtl/hot_page_mig_dispatcher_if.sv | 27 ++
 rtl/hot_page_mig_dispatcher_grp_fifo.sv | 69 ++++++
 rtl/hot_page_mig_dispatcher.sv | 158 +++++++++++++++
 tb/tb_hot_page_mig_dispatcher.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/hot_page_mig_dispatcher_pkg.sv
// hot_page_pkg: shared types for the hot-page migration dispatcher.
//   MIG_GRP_SIZE_DEF : default pairs per fetched group (both channels together)
//   pair_t           : one source/destination page pair (src in the upper 64 bits)
//   disp_state_t     : dispatcher FSM encoding
//   pair_is_null     : a pair with either address zero carries no copy
package hot_page_pkg;

   localparam int MIG_GRP_SIZE_DEF = 16;

   typedef struct packed {
      logic [63:0] src;
      logic [63:0] dst;
   } pair_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_ISSUE = 2'd2
   } disp_state_t;

   function automatic logic pair_is_null(input pair_t p);
      return (p.src == 64'd0) || (p.dst == 64'd0);
   endfunction

endpackage

// File: rtl/hot_page_mig_dispatcher_if.sv
// hot_page_mig_dispatcher_if: group-capture and copy-request bus of one channel.
//   new_addr_available/src_addr/dst_addr : group strobe and N_PAIRS address pairs
//   mig_req_valid/ready/src/dst          : copy request handshake
//   mig_cmpl_valid                       : one-cycle copy completion strobe
//   modport master : the dispatcher; modport slave : fetcher / copy engine side
interface hot_page_mig_dispatcher_if #(
   parameter int N_PAIRS = 8
);
   logic                     new_addr_available;
   logic [N_PAIRS-1:0][63:0] src_addr;
   logic [N_PAIRS-1:0][63:0] dst_addr;
   logic                     mig_req_valid;
   logic                     mig_req_ready;
   logic [63:0]              mig_req_src;
   logic [63:0]              mig_req_dst;
   logic                     mig_cmpl_valid;

   modport master (
      input  new_addr_available, src_addr, dst_addr, mig_req_ready, mig_cmpl_valid,
      output mig_req_valid, mig_req_src, mig_req_dst
   );

   modport slave (
      output new_addr_available, src_addr, dst_addr, mig_req_ready, mig_cmpl_valid,
      input  mig_req_valid, mig_req_src, mig_req_dst
   );
endinterface

// File: rtl/hot_page_mig_dispatcher_grp_fifo.sv
// hot_page_grp_fifo: GRP_DEPTH-entry buffer of whole address groups.
//   i_clk/i_rst_n        : clock, async active-low reset
//   i_push, i_wr_src/dst : write one full group into the tail slot (caller qualifies)
//   i_pop                : retire the head group
//   i_rd_idx, o_rd_pair  : combinational read of one pair of the head group
//   o_full/o_empty/o_count : occupancy status
module hot_page_grp_fifo
   import hot_page_pkg::*;
#(
   parameter int N_PAIRS   = 8,
   parameter int GRP_DEPTH = 2,
   parameter int IDX_W     = 3,
   parameter int CNT_W     = $clog2(GRP_DEPTH) + 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_push,
   input  logic [N_PAIRS-1:0][63:0] i_wr_src,
   input  logic [N_PAIRS-1:0][63:0] i_wr_dst,
   input  logic                     i_pop,
   input  logic [IDX_W-1:0]         i_rd_idx,
   output pair_t                    o_rd_pair,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [CNT_W-1:0]         o_count
);
   localparam int PTR_W = (GRP_DEPTH > 1) ? $clog2(GRP_DEPTH) : 1;

   pair_t            r_mem [GRP_DEPTH][N_PAIRS];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_empty;
   logic             w_pop;

   // Explicit wrap keeps non-power-of-2 depths in range as well.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(GRP_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
   endfunction

   assign w_empty   = (r_count == CNT_W'(0));
   assign w_pop     = i_pop && !w_empty;
   assign o_empty   = w_empty;
   assign o_full    = (r_count == CNT_W'(GRP_DEPTH));
   assign o_count   = r_count;
   assign o_rd_pair = r_mem[r_rd_ptr][i_rd_idx];

   // Group data array: the whole group lands in the tail slot in one cycle.
   always_ff @(posedge i_clk) begin
      if (i_push) begin
         for (int i = 0; i < N_PAIRS; i++) begin
            r_mem[r_wr_ptr][i] <= {i_wr_src[i], i_wr_dst[i]};
         end
      end
   end

   // Pointers and occupancy; push and pop may coincide.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= {PTR_W{1'b0}};
         r_rd_ptr <= {PTR_W{1'b0}};
         r_count  <= {CNT_W{1'b0}};
      end else begin
         if (i_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
         if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
         r_count <= r_count + CNT_W'(i_push) - CNT_W'(w_pop);
      end
   end
endmodule

// File: rtl/hot_page_mig_dispatcher.sv
// hot_page_mig_dispatcher: buffers address groups of one channel and issues
// non-null page pairs as copy requests, bounded by MAX_OUTSTANDING.
//   axi4_mm_clk / axi4_mm_rst_n : clock, async active-low reset
//   bus (master)                : group capture, copy request, completion
//   mig_done_cnt                : completed copies since reset (wraps)
//   grp_drop_cnt                : groups dropped on a full buffer (saturates)
//   cmpl_err                    : sticky, completion seen with nothing outstanding
//   busy                        : buffer non-empty or copies outstanding
module hot_page_mig_dispatcher
   import hot_page_pkg::*;
#(
   parameter int MIG_GRP_SIZE    = MIG_GRP_SIZE_DEF,
   parameter int GRP_DEPTH       = 2,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                    axi4_mm_clk,
   input  logic                    axi4_mm_rst_n,
   hot_page_mig_dispatcher_if.master bus,
   output logic [63:0]             mig_done_cnt,
   output logic [31:0]             grp_drop_cnt,
   output logic                    cmpl_err,
   output logic                    busy
);
   localparam int N_PAIRS = MIG_GRP_SIZE / 2;
   localparam int IDX_W   = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;
   localparam int CNT_W   = $clog2(GRP_DEPTH) + 1;
   localparam int OUT_W   = $clog2(MAX_OUTSTANDING + 1);

   disp_state_t      r_state;
   logic [IDX_W-1:0] r_idx;
   logic [OUT_W-1:0] r_outstanding;
   logic             r_req_valid;
   logic [63:0]      r_req_src;
   logic [63:0]      r_req_dst;
   logic [63:0]      r_done_cnt;
   logic [31:0]      r_drop_cnt;
   logic             r_cmpl_err;

   pair_t            w_head;
   logic             w_full;
   logic             w_empty;
   logic [CNT_W-1:0] w_count;
   logic             w_push;
   logic             w_drop;
   logic             w_null;
   logic             w_last;
   logic             w_issue;
   logic             w_pop;
   logic             w_more;
   logic             w_cmpl_ok;

   // A full buffer still accepts when its head retires in the same cycle.
   assign w_push    = bus.new_addr_available && (!w_full || w_pop);
   assign w_drop    = bus.new_addr_available && !w_push;
   assign w_null    = pair_is_null(w_head);
   assign w_last    = (r_idx == IDX_W'(N_PAIRS - 1));
   assign w_issue   = (r_state == ST_ISSUE) && r_req_valid && bus.mig_req_ready;
   assign w_pop     = w_last && (w_issue || ((r_state == ST_SCAN) && w_null));
   assign w_more    = (w_count > CNT_W'(1)) || w_push;
   // A same-cycle issue supplies the credit a completion retires.
   assign w_cmpl_ok = bus.mig_cmpl_valid && ((r_outstanding != OUT_W'(0)) || w_issue);

   hot_page_grp_fifo #(
      .N_PAIRS   (N_PAIRS),
      .GRP_DEPTH (GRP_DEPTH),
      .IDX_W     (IDX_W),
      .CNT_W     (CNT_W)
   ) u_grp_fifo (
      .i_clk     (axi4_mm_clk),
      .i_rst_n   (axi4_mm_rst_n),
      .i_push    (w_push),
      .i_wr_src  (bus.src_addr),
      .i_wr_dst  (bus.dst_addr),
      .i_pop     (w_pop),
      .i_rd_idx  (r_idx),
      .o_rd_pair (w_head),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_count   (w_count)
   );

   // Dispatcher FSM with registered request outputs.
   always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
      if (!axi4_mm_rst_n) begin
         r_state     <= ST_IDLE;
         r_idx       <= {IDX_W{1'b0}};
         r_req_valid <= 1'b0;
         r_req_src   <= 64'd0;
         r_req_dst   <= 64'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_idx <= {IDX_W{1'b0}};
               if (!w_empty) r_state <= ST_SCAN;
            end
            ST_SCAN: begin
               if (w_null) begin
                  if (w_last) begin
                     r_idx   <= {IDX_W{1'b0}};
                     r_state <= w_more ? ST_SCAN : ST_IDLE;
                  end else begin
                     r_idx <= r_idx + IDX_W'(1);
                  end
               end else if (r_outstanding < OUT_W'(MAX_OUTSTANDING)) begin
                  r_state     <= ST_ISSUE;
                  r_req_valid <= 1'b1;
                  r_req_src   <= w_head.src;
                  r_req_dst   <= w_head.dst;
               end
            end
            ST_ISSUE: begin
               if (w_issue) begin
                  r_req_valid <= 1'b0;
                  if (w_last) begin
                     r_idx   <= {IDX_W{1'b0}};
                     r_state <= w_more ? ST_SCAN : ST_IDLE;
                  end else begin
                     r_idx   <= r_idx + IDX_W'(1);
                     r_state <= ST_SCAN;
                  end
               end
            end
            default: begin
               r_state     <= ST_IDLE;
               r_idx       <= {IDX_W{1'b0}};
               r_req_valid <= 1'b0;
            end
         endcase
      end
   end

   // Outstanding credit, completion count, error flag and drop count.
   always_ff @(posedge axi4_mm_clk or negedge axi4_mm_rst_n) begin
      if (!axi4_mm_rst_n) begin
         r_outstanding <= {OUT_W{1'b0}};
         r_done_cnt    <= 64'd0;
         r_cmpl_err    <= 1'b0;
         r_drop_cnt    <= 32'd0;
      end else begin
         case ({w_issue, w_cmpl_ok})
            2'b10:   r_outstanding <= r_outstanding + OUT_W'(1);
            2'b01:   r_outstanding <= r_outstanding - OUT_W'(1);
            default: r_outstanding <= r_outstanding;
         endcase
         if (w_cmpl_ok) r_done_cnt <= r_done_cnt + 64'd1;
         if (bus.mig_cmpl_valid && !w_cmpl_ok) r_cmpl_err <= 1'b1;
         if (w_drop && (r_drop_cnt != 32'hFFFF_FFFF)) r_drop_cnt <= r_drop_cnt + 32'd1;
      end
   end

   assign bus.mig_req_valid = r_req_valid;
   assign bus.mig_req_src   = r_req_src;
   assign bus.mig_req_dst   = r_req_dst;
   assign mig_done_cnt      = r_done_cnt;
   assign grp_drop_cnt      = r_drop_cnt;
   assign cmpl_err          = r_cmpl_err;
   assign busy              = !w_empty || (r_outstanding != OUT_W'(0));
endmodule

// File: tb/tb_hot_page_mig_dispatcher.sv
// Directed bench: expected pairs are queued when a group is strobed and
// compared in order against the handshakes recorded by the monitor.
module tb_hot_page_mig_dispatcher;
   import hot_page_pkg::*;

   localparam int NP = 8;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hot_page_mig_dispatcher_if #(.N_PAIRS(NP)) bus ();

   logic [63:0] done_cnt;
   logic [31:0] drop_cnt;
   logic        cmpl_err;
   logic        busy;

   hot_page_mig_dispatcher #(
      .MIG_GRP_SIZE    (16),
      .GRP_DEPTH       (2),
      .MAX_OUTSTANDING (4)
   ) dut (
      .axi4_mm_clk   (clk),
      .axi4_mm_rst_n (rst_n),
      .bus           (bus),
      .mig_done_cnt  (done_cnt),
      .grp_drop_cnt  (drop_cnt),
      .cmpl_err      (cmpl_err),
      .busy          (busy)
   );

   int           vectors     = 0;
   int           miscompares = 0;
   logic         tb_cmpl     = 1'b0;
   logic         auto_cmpl   = 1'b0;
   bit           auto_en     = 1'b0;
   int           hs_cnt      = 0;
   int           obs_rd      = 0;
   longint       cyc         = 0;
   logic [127:0] obs_arr [256];
   longint       cmpl_q [$];
   logic [127:0] exp_q [$];

   assign bus.mig_cmpl_valid = tb_cmpl | auto_cmpl;

   // Monitor: records handshakes and returns completions 10 cycles later.
   always @(negedge clk) begin
      cyc = cyc + 1;
      auto_cmpl = 1'b0;
      if (!rst_n) begin
         cmpl_q.delete();
      end else begin
         if (bus.mig_req_valid && bus.mig_req_ready) begin
            obs_arr[hs_cnt % 256] = {bus.mig_req_src, bus.mig_req_dst};
            hs_cnt = hs_cnt + 1;
            if (auto_en) cmpl_q.push_back(cyc + 10);
         end
         if (auto_en && (cmpl_q.size() > 0) && (cmpl_q[0] <= cyc)) begin
            auto_cmpl = 1'b1;
            void'(cmpl_q.pop_front());
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic mk_group(input int k, output logic [NP-1:0][63:0] s, output logic [NP-1:0][63:0] d);
      for (int i = 0; i < NP; i++) begin
         s[i] = (64'(k) << 32) + 64'h1000 * 64'(i + 1);
         d[i] = (64'(k) << 32) + 64'h10_0000 + 64'h1000 * 64'(i);
      end
   endtask

   task automatic send_group(input logic [NP-1:0][63:0] s, input logic [NP-1:0][63:0] d, input bit accept);
      bus.src_addr = s;
      bus.dst_addr = d;
      bus.new_addr_available = 1'b1;
      if (accept) begin
         for (int i = 0; i < NP; i++) begin
            if ((s[i] != 64'd0) && (d[i] != 64'd0)) exp_q.push_back({s[i], d[i]});
         end
      end
      @(posedge clk);
      #1;
      bus.new_addr_available = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int max);
      int n = 0;
      while ((busy !== 1'b0) && (n < max)) begin
         cycle(1);
         n++;
      end
      chk(tag, busy, 1'b0);
   endtask

   task automatic wait_valid(input string tag, input int max);
      int n = 0;
      while ((bus.mig_req_valid !== 1'b1) && (n < max)) begin
         cycle(1);
         n++;
      end
      chk(tag, bus.mig_req_valid, 1'b1);
   endtask

   task automatic drain(input string tag);
      while ((exp_q.size() > 0) && (obs_rd < hs_cnt)) begin
         chk(tag, obs_arr[obs_rd % 256], exp_q.pop_front());
         obs_rd++;
      end
   endtask

   initial begin
      logic [NP-1:0][63:0] s, d, s2, d2, s3, d3;
      logic [63:0] snap_s, snap_d;
      int base, base2, n;

      bus.new_addr_available = 1'b0;
      bus.src_addr = '0;
      bus.dst_addr = '0;
      bus.mig_req_ready = 1'b0;

      // Reset state
      rst_n = 1'b0;
      cycle(3);
      chk("rst_valid", bus.mig_req_valid, 1'b0);
      chk("rst_src", bus.mig_req_src, 64'd0);
      chk("rst_dst", bus.mig_req_dst, 64'd0);
      chk("rst_done", done_cnt, 64'd0);
      chk("rst_drop", drop_cnt, 32'd0);
      chk("rst_err", cmpl_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      rst_n = 1'b1;
      cycle(2);

      // Completion while idle with nothing outstanding
      tb_cmpl = 1'b1;
      cycle(1);
      tb_cmpl = 1'b0;
      cycle(1);
      chk("idle_cmpl_err", cmpl_err, 1'b1);
      chk("idle_cmpl_done", done_cnt, 64'd0);

      // A: one full group, ready tied high, completions 10 cycles later
      auto_en = 1'b1;
      bus.mig_req_ready = 1'b1;
      base = hs_cnt;
      mk_group(0, s, d);
      send_group(s, d, 1'b1);
      chk("a_latency0", bus.mig_req_valid, 1'b0);
      cycle(1);
      chk("a_latency1", bus.mig_req_valid, 1'b0);
      wait_idle("a_idle", 400);
      drain("a_pair");
      chk("a_reqs", hs_cnt - base, 8);
      chk("a_done", done_cnt, 64'd8);
      chk("a_err_sticky", cmpl_err, 1'b1);

      // B: pairs 2 and 5 null
      base = hs_cnt;
      mk_group(1, s, d);
      s[2] = 64'd0;
      s[5] = 64'd0;
      send_group(s, d, 1'b1);
      wait_idle("b_idle", 400);
      drain("b_pair");
      chk("b_reqs", hs_cnt - base, 6);
      chk("b_done", done_cnt, 64'd14);

      // C: ready held low, then credit stall and a same-cycle issue+completion
      auto_en = 1'b0;
      bus.mig_req_ready = 1'b0;
      base = hs_cnt;
      mk_group(2, s, d);
      send_group(s, d, 1'b1);
      wait_valid("c_valid", 20);
      snap_s = bus.mig_req_src;
      snap_d = bus.mig_req_dst;
      for (int i = 0; i < 20; i++) begin
         cycle(1);
         chk("c_hold_valid", bus.mig_req_valid, 1'b1);
         chk("c_hold_src", bus.mig_req_src, snap_s);
         chk("c_hold_dst", bus.mig_req_dst, snap_d);
      end
      bus.mig_req_ready = 1'b1;
      cycle(40);
      chk("c_stall_reqs", hs_cnt - base, 4);
      chk("c_stall_valid", bus.mig_req_valid, 1'b0);
      chk("c_stall_busy", busy, 1'b1);
      bus.mig_req_ready = 1'b0;
      tb_cmpl = 1'b1;
      cycle(2);
      tb_cmpl = 1'b0;
      wait_valid("c_resume", 10);
      chk("c_done2", done_cnt, 64'd16);
      base2 = hs_cnt;
      tb_cmpl = 1'b1;
      bus.mig_req_ready = 1'b1;
      cycle(1);
      tb_cmpl = 1'b0;
      cycle(30);
      chk("c_same_cycle_reqs", hs_cnt - base2, 3);
      chk("c_done3", done_cnt, 64'd17);
      drain("c_pair");

      // F: reset while a request is pending with one group buffered
      bus.mig_req_ready = 1'b0;
      tb_cmpl = 1'b1;
      cycle(1);
      tb_cmpl = 1'b0;
      wait_valid("f_valid", 10);
      rst_n = 1'b0;
      #1;
      chk("f_async_valid", bus.mig_req_valid, 1'b0);
      chk("f_async_busy", busy, 1'b0);
      chk("f_async_done", done_cnt, 64'd0);
      exp_q.delete();
      cycle(2);
      rst_n = 1'b1;
      obs_rd = hs_cnt;
      base = hs_cnt;
      bus.mig_req_ready = 1'b1;
      cycle(30);
      chk("f_no_reqs", hs_cnt - base, 0);
      chk("f_idle_valid", bus.mig_req_valid, 1'b0);
      chk("f_err_clear", cmpl_err, 1'b0);

      // E: third back-to-back strobe dropped; strobe at head pop while full accepted
      bus.mig_req_ready = 1'b0;
      auto_en = 1'b1;
      base = hs_cnt;
      mk_group(10, s, d);
      mk_group(11, s2, d2);
      mk_group(12, s3, d3);
      send_group(s, d, 1'b1);
      send_group(s2, d2, 1'b1);
      send_group(s3, d3, 1'b0);
      chk("e_drop_third", drop_cnt, 32'd1);
      bus.mig_req_ready = 1'b1;
      n = 0;
      while (!((bus.mig_req_valid === 1'b1) && (hs_cnt - base == 7)) && (n < 200)) begin
         cycle(1);
         n++;
      end
      chk("e_pop_window", bus.mig_req_valid, 1'b1);
      mk_group(13, s, d);
      send_group(s, d, 1'b1);
      chk("e_drop_hold", drop_cnt, 32'd1);
      wait_idle("e_idle", 1000);
      drain("e_pair");
      chk("e_reqs", hs_cnt - base, 24);
      chk("e_done", done_cnt, 64'd24);
      chk("e_err", cmpl_err, 1'b0);
      chk("e_exp_left", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
